// File: rtl/key_event_sched.sv
// -----------------------------------------------------------------------------
// key_event_sched
//   Front-panel key controller. Takes debounced key_flag/key_state pairs from
//   NUM_KEYS key filters and classifies every press as short or long. The
//   resulting per-key events are round-robin arbitrated into a small FIFO that
//   a single valid/ready consumer drains.
//
//   Optional feature (macro KEY_REPEAT_EN):
//     defined   - while a key stays held after its long event, another long
//                 event is posted every REPEAT_CNT cycles until release.
//     undefined - exactly one long event per hold; REPEAT_CNT is unused.
//
// Parameters
//   NUM_KEYS    number of key channels (>= 2)
//   LONG_CNT    hold cycles that qualify a long press
//   REPEAT_CNT  auto-repeat period in cycles (KEY_REPEAT_EN only)
//   FIFO_DEPTH  event FIFO entries, power of 2 (>= 2)
//   CNT_W       hold counter width, 2^CNT_W > max(LONG_CNT, REPEAT_CNT)
//
// Ports
//   Clk        in   system clock
//   Rst_n      in   asynchronous active-low reset
//   key_flag   in   one-cycle debounced edge pulse per key
//   key_state  in   debounced level per key: 0 = pressed, 1 = released
//   evt_valid  out  FIFO head holds an event
//   evt_ready  in   consumer accepts the head this cycle
//   evt_key    out  key index of the head event (0 when empty)
//   evt_long   out  1 = long/repeat event, 0 = short (0 when empty)
//   overflow   out  sticky: an event was dropped since reset
// -----------------------------------------------------------------------------
module key_event_sched #(
  parameter int NUM_KEYS   = 4,
  parameter int LONG_CNT   = 25000000,
  parameter int REPEAT_CNT = 10000000,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 25
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic [NUM_KEYS-1:0]         key_flag,
  input  logic [NUM_KEYS-1:0]         key_state,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(NUM_KEYS)-1:0] evt_key,
  output logic                        evt_long,
  output logic                        overflow
);

  localparam int KEY_W  = $clog2(NUM_KEYS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
`endif

  // Reject configurations the counters or the FIFO pointers cannot represent.
  if (NUM_KEYS < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      LONG_CNT < 1 || REPEAT_CNT < 1 ||
      ((CNT_W < 31) && (LONG_CNT >= (1 << CNT_W) || REPEAT_CNT >= (1 << CNT_W))))
  begin : g_bad_params
    $error("key_event_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    K_IDLE,
    K_HELD,
    K_LONGD
  } key_st_e;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic             lng;
  } evt_t;

  // ---------------------------------------------------------------------------
  // Per-key state
  // ---------------------------------------------------------------------------
  key_st_e             key_st_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q    [NUM_KEYS];

  logic [NUM_KEYS-1:0] press, rel;
  logic [NUM_KEYS-1:0] hit_long, hit_rep;
  logic [NUM_KEYS-1:0] post, post_long;

  // Pending slot per key, overflow flag, arbiter pointer
  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic [NUM_KEYS-1:0] pend_long_q, pend_long_d;
  logic                overflow_q, overflow_d;
  logic [KEY_W-1:0]    rr_ptr_q, rr_ptr_d;

  // Arbiter
  logic [KEY_W-1:0]    scan_idx [NUM_KEYS];
  logic                gnt_valid;
  logic [KEY_W-1:0]    gnt_idx;

  // FIFO
  evt_t                mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic                push, pop;
  evt_t                head;

  // ---------------------------------------------------------------------------
  // Event detection: edges, thresholds and what each key posts this cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output is assigned a default before any
    // conditional logic, so no path can leave a value held (no latches).
    press     = key_flag & ~key_state;
    rel       = key_flag &  key_state;
    hit_long  = '0;
    hit_rep   = '0;
    post      = '0;
    post_long = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit_long[i] = (key_st_q[i] == K_HELD) && (cnt_q[i] == LONG_LAST);
`ifdef KEY_REPEAT_EN
      hit_rep[i]  = (key_st_q[i] == K_LONGD) && (cnt_q[i] == REPEAT_LAST);
`endif
      // A release coinciding with the long threshold yields the long event only.
      post_long[i] = hit_long[i] | hit_rep[i];
      post[i]      = post_long[i] | ((key_st_q[i] == K_HELD) & rel[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key press classifier FSMs
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!Rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_st_q[i] <= K_IDLE;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        unique case (key_st_q[i])
          K_IDLE: begin
            if (press[i]) begin
              key_st_q[i] <= K_HELD;
              cnt_q[i]    <= '0;
            end
          end
          K_HELD: begin
            if (hit_long[i]) begin
              key_st_q[i] <= rel[i] ? K_IDLE : K_LONGD;
              cnt_q[i]    <= '0;
            end else if (rel[i]) begin
              key_st_q[i] <= K_IDLE;
              cnt_q[i]    <= '0;
            end else begin
              cnt_q[i]    <= cnt_q[i] + CNT_W'(1);
            end
          end
          K_LONGD: begin
            if (rel[i]) begin
              key_st_q[i] <= K_IDLE;
              cnt_q[i]    <= '0;
            end
`ifdef KEY_REPEAT_EN
            else if (hit_rep[i]) begin
              cnt_q[i]    <= '0;
            end else begin
              cnt_q[i]    <= cnt_q[i] + CNT_W'(1);
            end
`endif
          end
          default: begin
            key_st_q[i] <= K_IDLE;
            cnt_q[i]    <= '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first pending key at or above rr_ptr, wrapping
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      scan_idx[k] = KEY_W'((int'(rr_ptr_q) + k) % NUM_KEYS);
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (fifo_cnt_q < FCNT_W'(FIFO_DEPTH)) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (!gnt_valid && pend_q[scan_idx[k]]) begin
          gnt_valid = 1'b1;
          gnt_idx   = scan_idx[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending slots and overflow. A key whose slot is still occupied at the time
  // it posts loses the new event, even if the slot drains in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d      = pend_q;
    pend_long_d = pend_long_q;
    overflow_d  = overflow_q;
    rr_ptr_d    = rr_ptr_q;
    if (gnt_valid) begin
      pend_d[gnt_idx] = 1'b0;
      rr_ptr_d        = (gnt_idx == KEY_W'(NUM_KEYS - 1)) ? '0 : gnt_idx + KEY_W'(1);
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (post[i]) begin
        if (pend_q[i]) begin
          overflow_d = 1'b1;
        end else begin
          pend_d[i]      = 1'b1;
          pend_long_d[i] = post_long[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign push = gnt_valid;
  assign pop  = evt_valid & evt_ready;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend_q      <= '0;
      pend_long_q <= '0;
      overflow_q  <= 1'b0;
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
      overflow_q  <= overflow_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // NOTE: the storage array has no reset; its contents only matter once the
  // reset count says an entry is valid, and the outputs are gated by that.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{key: gnt_idx, lng: pend_long_q[gnt_idx]};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign head      = mem_q[rd_ptr_q];
  assign evt_valid = (fifo_cnt_q != '0);
  assign evt_key   = evt_valid ? head.key : '0;
  assign evt_long  = evt_valid ? head.lng : 1'b0;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_sched.sv
// -----------------------------------------------------------------------------
// tb_key_event_sched
//   Self-checking bench for key_event_sched (NUM_KEYS=4, LONG_CNT=20,
//   REPEAT_CNT=10, FIFO_DEPTH=4). A behavioural reference model, based on hold
//   durations measured from the press cycle and a queue for the FIFO, is
//   compared against the DUT every cycle. On top of that, a table of
//   single-key hold vectors and a few hand-written sequences check latency,
//   arbitration order, overflow and reset behaviour directly.
// -----------------------------------------------------------------------------
module tb_key_event_sched;

  localparam int NK    = 4;
  localparam int LONG  = 20;
  localparam int RPT   = 10;
  localparam int FD    = 4;
  localparam int CW    = 5;
`ifdef KEY_REPEAT_EN
  localparam int REP   = 1;
`else
  localparam int REP   = 0;
`endif

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic [NK-1:0] key_flag;
  logic [NK-1:0] key_state;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_key;
  logic          evt_long;
  logic          overflow;

  key_event_sched #(
    .NUM_KEYS  (NK),
    .LONG_CNT  (LONG),
    .REPEAT_CNT(RPT),
    .FIFO_DEPTH(FD),
    .CNT_W     (CW)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .key_flag (key_flag),
    .key_state(key_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key  (evt_key),
    .evt_long (evt_long),
    .overflow (overflow)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0] key;
    logic       lng;
  } mevt_t;

  mevt_t     m_fifo [$];
  bit        m_held  [NK];
  int        m_start [NK];
  bit [NK-1:0] m_pend, m_pend_long;
  int        m_rr;
  bit        m_ovf;
  int        m_cyc;

  function automatic void model_reset();
    m_fifo.delete();
    for (int k = 0; k < NK; k++) begin
      m_held[k]  = 1'b0;
      m_start[k] = 0;
    end
    m_pend      = '0;
    m_pend_long = '0;
    m_rr        = 0;
    m_ovf       = 1'b0;
    m_cyc       = 0;
  endfunction

  // One clock edge: uses the inputs applied during the cycle just ending.
  function automatic void model_step();
    bit          pop;
    int          gnt;
    bit [NK-1:0] np, npl;
    pop = (m_fifo.size() != 0) && evt_ready;
    gnt = -1;
    if (m_fifo.size() < FD) begin
      for (int j = 0; j < NK; j++) begin
        int k;
        k = (m_rr + j) % NK;
        if (gnt < 0 && m_pend[k]) gnt = k;
      end
    end
    np  = m_pend;
    npl = m_pend_long;
    if (gnt >= 0) np[gnt] = 1'b0;
    for (int k = 0; k < NK; k++) begin
      bit pr, rl, post, plong;
      int d;
      pr    = key_flag[k] & ~key_state[k];
      rl    = key_flag[k] &  key_state[k];
      post  = 1'b0;
      plong = 1'b0;
      if (m_held[k]) begin
        d = m_cyc - m_start[k];          // cycles since the press cycle
        if (d == LONG) begin
          post = 1'b1; plong = 1'b1;
        end else if (REP != 0 && d > LONG && ((d - LONG) % RPT) == 0) begin
          post = 1'b1; plong = 1'b1;
        end else if (rl && d < LONG) begin
          post = 1'b1;
        end
        if (rl) m_held[k] = 1'b0;
      end else if (pr) begin
        m_held[k]  = 1'b1;
        m_start[k] = m_cyc;
      end
      if (post) begin
        if (m_pend[k]) begin
          m_ovf = 1'b1;
        end else begin
          np[k]  = 1'b1;
          npl[k] = plong;
        end
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (gnt >= 0) begin
      m_fifo.push_back('{key: 2'(gnt), lng: m_pend_long[gnt]});
      m_rr = (gnt + 1) % NK;
    end
    m_pend      = np;
    m_pend_long = npl;
    m_cyc++;
  endfunction

  function automatic logic [4:0] model_out();
    mevt_t h;
    if (m_fifo.size() == 0) return {1'b0, 2'b00, 1'b0, m_ovf};
    h = m_fifo[0];
    return {1'b1, h.key, h.lng, m_ovf};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Called at a falling edge; return at the next one with the
  // DUT outputs of the following cycle visible and checked against the model.
  // ---------------------------------------------------------------------------
  logic [NK-1:0] lvl;
  int            got_key  [$];
  int            got_long [$];

  task automatic cycle(input logic [NK-1:0] press_m, input logic [NK-1:0] rel_m,
                       input logic rdy);
    lvl       = (lvl & ~press_m) | rel_m;
    key_flag  = press_m | rel_m;
    key_state = lvl;
    evt_ready = rdy;
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check("model", {27'd0, evt_valid, evt_key, evt_long, overflow}, {27'd0, model_out()});
  endtask

  task automatic short_press(input int k, input logic rdy);
    logic [NK-1:0] m;
    m = '0;
    m[k] = 1'b1;
    cycle(m, '0, rdy);
    cycle('0, '0, rdy);
    cycle('0, '0, rdy);
    cycle('0, m, rdy);
    cycle('0, '0, rdy);
  endtask

  // Run ncyc cycles with ready high, recording every accepted event.
  task automatic drain(input int ncyc);
    got_key.delete();
    got_long.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (evt_valid) begin
        got_key.push_back(int'(evt_key));
        got_long.push_back(int'(evt_long));
      end
      cycle('0, '0, 1'b1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Table of single-key hold vectors (ready held high)
  // ---------------------------------------------------------------------------
  typedef struct {
    int key;        // key pressed
    int hold;       // cycles from press flag to release flag
    int exp_n;      // events expected in total
    int exp_first;  // cycles from press flag to first evt_valid
    int exp_long;   // long bit of the first event
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    Rst_n     = 1'b0;
    key_flag  = '0;
    key_state = '1;
    lvl       = '1;
    evt_ready = 1'b0;

    vecs[0] = '{key: 1, hold: 5,  exp_n: 1,           exp_first: 7,  exp_long: 0};
    vecs[1] = '{key: 0, hold: 1,  exp_n: 1,           exp_first: 3,  exp_long: 0};
    vecs[2] = '{key: 3, hold: 19, exp_n: 1,           exp_first: 21, exp_long: 0};
    vecs[3] = '{key: 2, hold: 20, exp_n: 1,           exp_first: 22, exp_long: 1};
    vecs[4] = '{key: 2, hold: 21, exp_n: 1,           exp_first: 22, exp_long: 1};
    vecs[5] = '{key: 2, hold: 45, exp_n: 1 + 2 * REP, exp_first: 22, exp_long: 1};
    vecs[6] = '{key: 0, hold: 30, exp_n: 1 + REP,     exp_first: 22, exp_long: 1};

    // ---- reset state
    repeat (2) @(negedge Clk);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_key",   {30'd0, evt_key},   32'd0);
    check("rst_long",  {31'd0, evt_long},  32'd0);
    check("rst_ovf",   {31'd0, overflow},  32'd0);
    model_reset();
    Rst_n = 1'b1;

    // ---- table vectors
    for (int v = 0; v < NV; v++) begin
      int            n, first;
      logic [1:0]    fk;
      logic          fl;
      logic [NK-1:0] pm, rm;
      n     = 0;
      first = -1;
      fk    = 'x;
      fl    = 1'bx;
      for (int c = 0; c < vecs[v].hold + 35; c++) begin
        if (evt_valid) begin
          if (first < 0) begin
            first = c;
            fk    = evt_key;
            fl    = evt_long;
          end
          n++;
        end
        pm = '0;
        rm = '0;
        if (c == 0)            pm[vecs[v].key] = 1'b1;
        if (c == vecs[v].hold) rm[vecs[v].key] = 1'b1;
        cycle(pm, rm, 1'b1);
      end
      check($sformatf("v%0d_count", v), n,             vecs[v].exp_n);
      check($sformatf("v%0d_lat", v),   first,         vecs[v].exp_first);
      check($sformatf("v%0d_key", v),   {30'd0, fk},   vecs[v].key);
      check($sformatf("v%0d_long", v),  {31'd0, fl},   vecs[v].exp_long);
    end

    // ---- simultaneous releases with rr_ptr = 2 (after a key1 grant)
    short_press(1, 1'b1);
    drain(4);
    cycle(4'b1011, '0, 1'b1);
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b1);
    cycle('0, 4'b1011, 1'b1);
    drain(8);
    check("rr_count", got_key.size(), 3);
    if (got_key.size() == 3) begin
      check("rr_first",  got_key[0], 3);
      check("rr_second", got_key[1], 0);
      check("rr_third",  got_key[2], 1);
    end

    // ---- full FIFO, pending slots, overflow
    for (int k = 0; k < NK; k++) short_press(k, 1'b0);
    short_press(0, 1'b0);
    short_press(1, 1'b0);
    check("full_valid", {31'd0, evt_valid}, 32'd1);
    check("full_head",  {30'd0, evt_key},   32'd0);
    check("pre_ovf",    {31'd0, overflow},  32'd0);
    short_press(0, 1'b0);
    check("ovf_set",    {31'd0, overflow},  32'd1);
    drain(12);
    check("ovf_drain_count", got_key.size(), 6);
    if (got_key.size() == 6) begin
      for (int j = 0; j < 6; j++) begin
        check($sformatf("ovf_order%0d", j), got_key[j], j % 4);
      end
    end
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // ---- reset in the middle of a hold, with an event queued
    short_press(3, 1'b0);
    cycle(4'b0010, '0, 1'b0);
    for (int c = 0; c < 9; c++) cycle('0, '0, 1'b0);
    Rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, evt_valid}, 32'd0);
    check("mid_rst_key",   {30'd0, evt_key},   32'd0);
    check("mid_rst_long",  {31'd0, evt_long},  32'd0);
    check("mid_rst_ovf",   {31'd0, overflow},  32'd0);
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    cycle('0, 4'b0010, 1'b1);
    drain(30);
    check("rst_release_silent", got_key.size(), 0);

    // ---- stray release and re-press while held
    cycle('0, 4'b0100, 1'b1);
    cycle(4'b0001, '0, 1'b1);
    cycle('0, '0, 1'b1);
    cycle(4'b0001, '0, 1'b1);
    cycle('0, '0, 1'b1);
    cycle('0, 4'b0001, 1'b1);
    drain(10);
    check("stray_count", got_key.size(), 1);
    if (got_key.size() == 1) begin
      check("stray_key",  got_key[0],  0);
      check("stray_long", got_long[0], 0);
    end
    check("stray_ovf", {31'd0, overflow}, 32'd0);

    // ---- randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [NK-1:0] f, s;
      for (int k = 0; k < NK; k++) begin
        f[k] = ($urandom_range(31) == 0);
        s[k] = 1'($urandom_range(1));
      end
      cycle(f & ~s, f & s, ($urandom_range(3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
